// File: rtl/sequenciador_calc_pkg.sv
// Shared definitions for the calculator instruction sequencer: opcodes,
// one-hot ULA codes, FSM states and instruction field positions.
package calc_pkg;

  // Instruction opcodes in bits [31:29]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_MCLR = 3'b100;
  localparam logic [2:0] OP_ILL  = 3'b101;
  localparam logic [2:0] OP_MRD  = 3'b110;
  localparam logic [2:0] OP_MWR  = 3'b111;

  // One-hot operation select presented to the ULA
  localparam logic [3:0] ULA_ADD = 4'b1000;
  localparam logic [3:0] ULA_SUB = 4'b0100;
  localparam logic [3:0] ULA_DIV = 4'b0001;
  localparam logic [3:0] ULA_MUL = 4'b0010;
  localparam logic [3:0] ULA_NOP = 4'b0000;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;
  localparam int RA_MSB  = 28;
  localparam int RA_LSB  = 27;
  localparam int RB_MSB  = 26;
  localparam int RB_LSB  = 25;
  localparam int IMM_MSB = 24;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ULA_GO,
    ST_ULA_WAIT,
    ST_MEM,
    ST_WB,
    ST_NEXT,
    ST_DONE
  } estado_t;

  // Retired-instruction counter increment that sticks at all-ones
  function automatic logic [15:0] inc_sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sequenciador_calc_if.sv
// Bundle of the sequencer's program-memory, ULA, data-memory, register-file
// and status signals. The sequencer is the master side.
interface sequenciador_calc_if #(
  parameter int PC_WIDTH = 8
);
  logic                _start;
  logic [PC_WIDTH-1:0] _pc;
  logic                _instr_req;
  logic                _instr_valid;
  logic [31:0]         _instrucao;
  logic                _ula_start;
  logic [3:0]          _ula_op;
  logic                _ula_done;
  logic                _mem_req;
  logic [2:0]          _mem_control;
  logic                _mem_ack;
  logic                _reg_write;
  logic [1:0]          _reg_dest;
  logic [24:0]         _imediato;
  logic                _busy;
  logic                _halt;
  logic                _erro;
  logic [15:0]         _contador;

  modport master (
    input  _start, _instr_valid, _instrucao, _ula_done, _mem_ack,
    output _pc, _instr_req, _ula_start, _ula_op, _mem_req, _mem_control,
           _reg_write, _reg_dest, _imediato, _busy, _halt, _erro, _contador
  );

  modport slave (
    output _start, _instr_valid, _instrucao, _ula_done, _mem_ack,
    input  _pc, _instr_req, _ula_start, _ula_op, _mem_req, _mem_control,
           _reg_write, _reg_dest, _imediato, _busy, _halt, _erro, _contador
  );
endinterface

// File: rtl/sequenciador_calc_decodificador_instr.sv
// Combinational instruction decoder: splits the latched instruction into
// ULA select, memory opcode, destination register, immediate and class flags.
module decodificador_instr
  import calc_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  ula_op,
  output logic [2:0]  mem_control,
  output logic [1:0]  reg_dest,
  output logic [24:0] imediato,
  output logic        is_ula,
  output logic        is_mem,
  output logic        is_illegal
);

  logic [2:0] opc;

  assign opc      = ir[OPC_MSB:OPC_LSB];
  assign imediato = ir[IMM_MSB:IMM_LSB];

  // Opcode classification and per-class field selection
  always_comb begin
    ula_op      = ULA_NOP;
    mem_control = 3'b000;
    reg_dest    = ir[RA_MSB:RA_LSB];
    is_ula      = 1'b0;
    is_mem      = 1'b0;
    is_illegal  = 1'b0;
    case (opc)
      OP_ADD:  begin ula_op = ULA_ADD; is_ula = 1'b1; end
      OP_SUB:  begin ula_op = ULA_SUB; is_ula = 1'b1; end
      OP_DIV:  begin ula_op = ULA_DIV; is_ula = 1'b1; end
      OP_MUL:  begin ula_op = ULA_MUL; is_ula = 1'b1; end
      OP_MCLR: begin mem_control = OP_MCLR; is_mem = 1'b1; end
      OP_MRD:  begin
        mem_control = OP_MRD;
        is_mem      = 1'b1;
        reg_dest    = ir[RB_MSB:RB_LSB];
      end
      OP_MWR:  begin mem_control = OP_MWR; is_mem = 1'b1; end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sequenciador_calc.sv
// Multi-cycle instruction sequencer: fetches by PC, decodes, runs the ULA or
// data-memory handshake, issues register writeback and counts retirements.
module sequenciador_calc
  import calc_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] ULTIMO_PC   = 8'd255,
  parameter int                  ULA_TIMEOUT = 32
)(
  input logic                 _clock,
  input logic                 _reset,
  sequenciador_calc_if.master bus
);

  localparam int TMO_W = $clog2(ULA_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ULA_TIMEOUT - 1);

  estado_t             state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         ir_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [15:0]         contador_q;
  logic                erro_q;
  logic                instr_req_q;
  logic                ula_start_q;
  logic                mem_req_q;
  logic                reg_write_q;
  logic                busy_q;
  logic                halt_q;
  logic [3:0]          ula_op_q;
  logic [2:0]          mem_ctl_q;

  logic [3:0]  dec_ula_op;
  logic [2:0]  dec_mem_control;
  logic [1:0]  dec_reg_dest;
  logic [24:0] dec_imediato;
  logic        dec_is_ula;
  logic        dec_is_mem;
  logic        dec_is_illegal;

  decodificador_instr u_dec (
    .ir          (ir_q),
    .ula_op      (dec_ula_op),
    .mem_control (dec_mem_control),
    .reg_dest    (dec_reg_dest),
    .imediato    (dec_imediato),
    .is_ula      (dec_is_ula),
    .is_mem      (dec_is_mem),
    .is_illegal  (dec_is_illegal)
  );

  // Sequencer FSM with registered handshake, strobe and status outputs
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state       <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      tmo_q       <= '0;
      contador_q  <= '0;
      erro_q      <= 1'b0;
      instr_req_q <= 1'b0;
      ula_start_q <= 1'b0;
      mem_req_q   <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      halt_q      <= 1'b0;
      ula_op_q    <= ULA_NOP;
      mem_ctl_q   <= 3'b000;
    end else begin
      // single-cycle strobes fall back unless re-armed below
      ula_start_q <= 1'b0;
      reg_write_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus._start) begin
            pc_q        <= '0;
            erro_q      <= 1'b0;
            contador_q  <= '0;
            instr_req_q <= 1'b1;
            busy_q      <= 1'b1;
            halt_q      <= 1'b0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus._instr_valid) begin
            ir_q        <= bus._instrucao;
            instr_req_q <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_is_ula) begin
            ula_start_q <= 1'b1;
            ula_op_q    <= dec_ula_op;
            state       <= ST_ULA_GO;
          end else if (dec_is_mem) begin
            mem_req_q   <= 1'b1;
            mem_ctl_q   <= dec_mem_control;
            state       <= ST_MEM;
          end else begin
            if (dec_is_illegal) erro_q <= 1'b1;
            state <= ST_NEXT;
          end
        end
        ST_ULA_GO: begin
          // a zero-latency ULA may answer in the same cycle as the start pulse
          if (bus._ula_done) begin
            ula_op_q    <= ULA_NOP;
            reg_write_q <= 1'b1;
            state       <= ST_WB;
          end else begin
            tmo_q <= '0;
            state <= ST_ULA_WAIT;
          end
        end
        ST_ULA_WAIT: begin
          if (bus._ula_done) begin
            ula_op_q    <= ULA_NOP;
            reg_write_q <= 1'b1;
            state       <= ST_WB;
          end else if (tmo_q == TMO_LAST) begin
            ula_op_q <= ULA_NOP;
            erro_q   <= 1'b1;
            state    <= ST_NEXT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_MEM: begin
          if (bus._mem_ack) begin
            mem_req_q <= 1'b0;
            mem_ctl_q <= 3'b000;
            if (mem_ctl_q == OP_MRD) begin
              reg_write_q <= 1'b1;
              state       <= ST_WB;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_WB: begin
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          contador_q <= inc_sat16(contador_q);
          if (pc_q == ULTIMO_PC) begin
            busy_q <= 1'b0;
            halt_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            pc_q        <= pc_q + PC_WIDTH'(1);
            instr_req_q <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus._pc          = pc_q;
  assign bus._instr_req   = instr_req_q;
  assign bus._ula_start   = ula_start_q;
  assign bus._ula_op      = ula_op_q;
  assign bus._mem_req     = mem_req_q;
  assign bus._mem_control = mem_ctl_q;
  assign bus._reg_write   = reg_write_q;
  assign bus._reg_dest    = dec_reg_dest;
  assign bus._imediato    = dec_imediato;
  assign bus._busy        = busy_q;
  assign bus._halt        = halt_q;
  assign bus._erro        = erro_q;
  assign bus._contador    = contador_q;

endmodule
